// File: rtl/bloc_ceas.sv
// BCD hours/minutes/seconds timekeeping core with RUN / SET_H / SET_M mode FSM.
// Define BLOC_CEAS_12H_EN for the 12-hour format with pm flag; otherwise 24-hour format.
module bloc_ceas #(
    parameter logic [7:0] RESET_HOUR_BCD = 8'h12,
    parameter logic [7:0] RESET_MIN_BCD  = 8'h00
) (
    input  logic       clk_FPGA,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_inc,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic [1:0] mode,
    output logic       blink,
    output logic       min_pulse
);

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] SET_H = 2'b01;
    localparam logic [1:0] SET_M = 2'b10;

    logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [1:0] mode_q, mode_d;
    logic       pm_q, pm_d, blink_q, blink_d, mp_q, mp_d, ph_q, ph_d;
    logic       hour_step;

    // Modulo-60 BCD increment shared by minutes and seconds.
    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
`ifdef BLOC_CEAS_12H_EN
        if (v == 8'h12) return 8'h01;
`else
        if (v >= 8'h23) return 8'h00;
`endif
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        mode_d    = mode_q;
        ph_d      = ph_q;
        mp_d      = 1'b0;
        hour_step = 1'b0;
        case (mode_q)
            RUN: begin
                ph_d = 1'b0;
                if (tick_1hz) begin
                    sec_d = inc_60(sec_q);
                    if (sec_q == 8'h59) begin
                        mp_d  = 1'b1;
                        min_d = inc_60(min_q);
                        if (min_q == 8'h59) hour_step = 1'b1;
                    end
                end
                if (btn_mode) mode_d = SET_H;
            end
            SET_H: begin
                if (tick_inc && btn_inc) hour_step = 1'b1;
                if (tick_inc) ph_d = ~ph_q;
                if (btn_mode) mode_d = SET_M;
            end
            SET_M: begin
                if (tick_inc && btn_inc) min_d = inc_60(min_q);
                if (tick_inc) ph_d = ~ph_q;
                if (btn_mode) begin
                    mode_d = RUN;
                    sec_d  = 8'h00;
                end
            end
            default: mode_d = RUN;
        endcase
        if (hour_step) hour_d = inc_hour(hour_q);
`ifdef BLOC_CEAS_12H_EN
        pm_d = pm_q ^ (hour_step && (hour_q == 8'h11));
`else
        pm_d = 1'b0;
`endif
        // Holding increment keeps the field being set visible.
        blink_d = (mode_d != RUN) && !btn_inc && ph_d;
    end

    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            hour_q  <= RESET_HOUR_BCD;
            min_q   <= RESET_MIN_BCD;
            sec_q   <= 8'h00;
            mode_q  <= RUN;
            pm_q    <= 1'b0;
            blink_q <= 1'b0;
            mp_q    <= 1'b0;
            ph_q    <= 1'b0;
        end else begin
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            mode_q  <= mode_d;
            pm_q    <= pm_d;
            blink_q <= blink_d;
            mp_q    <= mp_d;
            ph_q    <= ph_d;
        end
    end

    assign hour_bcd  = hour_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign mode      = mode_q;
    assign pm        = pm_q;
    assign blink     = blink_q;
    assign min_pulse = mp_q;

endmodule

// File: tb/tb_bloc_ceas.sv
// Self-checking bench for bloc_ceas: directed table, hand-written rollover sequences,
// and randomized stimulus against a seconds-of-day reference model.
module tb_bloc_ceas;

    logic       clk_FPGA = 1'b0;
    logic       reset = 1'b0, tick_1hz = 1'b0, tick_inc = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       pm, blink, min_pulse;
    logic [1:0] mode;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: time as seconds of day (hour 0 = midnight), mode as 0/1/2.
    int m_t, m_mode, m_ph, m_blink, m_mp;

    bloc_ceas dut (
        .clk_FPGA (clk_FPGA), .reset (reset), .tick_1hz (tick_1hz), .tick_inc (tick_inc),
        .btn_mode (btn_mode), .btn_inc (btn_inc), .hour_bcd (hour_bcd), .min_bcd (min_bcd),
        .sec_bcd (sec_bcd), .pm (pm), .mode (mode), .blink (blink), .min_pulse (min_pulse)
    );

    always #5 clk_FPGA = ~clk_FPGA;

    typedef struct {
        logic       rst, t1, ti, bm, bi;
        logic [7:0] eh, em, es;
        logic [1:0] emode;
        logic       eblink, emp;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic rst, t1, ti, bm, bi, input logic [7:0] eh, em, es,
                                input logic [1:0] emode, input logic eblink, emp);
        vec_t v;
        v.rst = rst; v.t1 = t1; v.ti = ti; v.bm = bm; v.bi = bi;
        v.eh = eh; v.em = em; v.es = es; v.emode = emode; v.eblink = eblink; v.emp = emp;
        return v;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, t1, ti, bm, bi);
        int mins;
        if (r) begin
`ifdef BLOC_CEAS_12H_EN
            m_t = 0;
`else
            m_t = 12 * 3600;
`endif
            m_mode = 0; m_ph = 0; m_blink = 0; m_mp = 0;
            return;
        end
        m_mp = 0;
        case (m_mode)
            0: begin
                if (t1) begin
                    if (m_t % 60 == 59) m_mp = 1;
                    m_t = (m_t + 1) % 86400;
                end
                m_ph = 0;
                if (bm) m_mode = 1;
            end
            1: begin
                if (ti && bi) m_t = (m_t + 3600) % 86400;
                if (ti) m_ph = 1 - m_ph;
                if (bm) m_mode = 2;
            end
            default: begin
                if (ti && bi) begin
                    mins = (m_t / 60) % 60;
                    m_t  = m_t - mins * 60 + ((mins + 1) % 60) * 60;
                end
                if (ti) m_ph = 1 - m_ph;
                if (bm) begin
                    m_mode = 0;
                    m_t    = m_t - (m_t % 60);
                end
            end
        endcase
        m_blink = (m_mode != 0 && !bi && m_ph != 0) ? 1 : 0;
    endtask

    task automatic check_model();
        int h, hd;
        h = m_t / 3600;
`ifdef BLOC_CEAS_12H_EN
        hd = (h % 12 == 0) ? 12 : h % 12;
        chk("pm", pm, (h >= 12) ? 1 : 0);
`else
        hd = h;
        chk("pm", pm, 0);
`endif
        chk("hour", hour_bcd, bcd(hd));
        chk("min", min_bcd, bcd((m_t / 60) % 60));
        chk("sec", sec_bcd, bcd(m_t % 60));
        chk("mode", mode, m_mode);
        chk("blink", blink, m_blink);
        chk("min_pulse", min_pulse, m_mp);
    endtask

    task automatic cyc(input logic r, t1, ti, bm, bi);
        reset = r; tick_1hz = t1; tick_inc = ti; btn_mode = bm; btn_inc = bi;
        @(posedge clk_FPGA);
        #1;
        model_step(r, t1, ti, bm, bi);
        reset = 0; tick_1hz = 0; tick_inc = 0; btn_mode = 0; btn_inc = 0;
    endtask

    initial begin
        //            rst t1 ti bm bi   hour   min    sec    mode  blink mp
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 2'd0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00, 2'd0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 8'h12, 8'h00, 8'h01, 2'd0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 1, 8'h12, 8'h00, 8'h02, 2'd0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 8'h12, 8'h00, 8'h03, 2'd1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 8'h12, 8'h00, 8'h03, 2'd1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 8'h12, 8'h00, 8'h03, 2'd1, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 8'h12, 8'h00, 8'h03, 2'd1, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 8'h12, 8'h00, 8'h03, 2'd1, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 8'h12, 8'h00, 8'h03, 2'd1, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, 8'h12, 8'h00, 8'h03, 2'd2, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 1, 8'h12, 8'h01, 8'h03, 2'd2, 0, 0);
        tbl[12] = mk(0, 0, 1, 1, 1, 8'h12, 8'h02, 8'h00, 2'd0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 8'h12, 8'h02, 8'h01, 2'd0, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 8'h12, 8'h02, 8'h01, 2'd1, 0, 0);
        tbl[15] = mk(1, 1, 1, 0, 1, 8'h12, 8'h00, 8'h00, 2'd0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].t1, tbl[i].ti, tbl[i].bm, tbl[i].bi);
            chk($sformatf("tbl%0d.hour", i), hour_bcd, tbl[i].eh);
            chk($sformatf("tbl%0d.min", i), min_bcd, tbl[i].em);
            chk($sformatf("tbl%0d.sec", i), sec_bcd, tbl[i].es);
            chk($sformatf("tbl%0d.mode", i), mode, tbl[i].emode);
            chk($sformatf("tbl%0d.blink", i), blink, tbl[i].eblink);
            chk($sformatf("tbl%0d.mp", i), min_pulse, tbl[i].emp);
            chk($sformatf("tbl%0d.pm", i), pm, 0);
        end

        // Preset to hh:59:58 via the set modes (24h: 23, 12h: 11 am).
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 11; i++) begin cyc(0, 1, 1, 0, 1); check_model(); end
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) begin cyc(0, 1, 1, 0, 1); check_model(); end
        cyc(0, 0, 0, 1, 0);
        check_model();
        for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
`ifdef BLOC_CEAS_12H_EN
        chk("pre_roll.hour", hour_bcd, 8'h11);
`else
        chk("pre_roll.hour", hour_bcd, 8'h23);
`endif
        chk("pre_roll.sec", sec_bcd, 8'h59);
        chk("pre_roll.mp", min_pulse, 0);
        cyc(0, 1, 0, 0, 0);
`ifdef BLOC_CEAS_12H_EN
        chk("roll.hour", hour_bcd, 8'h12);
        chk("roll.pm", pm, 1);
`else
        chk("roll.hour", hour_bcd, 8'h00);
`endif
        chk("roll.min", min_bcd, 8'h00);
        chk("roll.sec", sec_bcd, 8'h00);
        chk("roll.mp", min_pulse, 1);
        cyc(0, 0, 0, 0, 0);
        chk("roll_after.mp", min_pulse, 0);
        check_model();
`ifdef BLOC_CEAS_12H_EN
        for (int i = 0; i < 3599; i++) cyc(0, 1, 0, 0, 0);
        check_model();
        cyc(0, 1, 0, 0, 0);
        chk("h12_to_01.hour", hour_bcd, 8'h01);
        chk("h12_to_01.pm", pm, 1);
`endif

        // SET_H with increment held and 1 Hz ticks present: ticks ignored, blink stays low.
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 1);
            check_model();
            chk("seth.blink", blink, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check_model();

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                $urandom_range(0, 1) == 1);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
